// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the manager arbiter.
//   HTRANS / HBURST encodings, the bus-owner type, and burst_len(), which maps
//   an HBURST code to (beats - 1) for fixed-length bursts and 0 otherwise.
package ahb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] NSEQ = 2'd2;
  localparam logic [1:0] SEQ  = 2'd3;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] WRAP4  = 3'd2;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] WRAP16 = 3'd6;
  localparam logic [2:0] INCR16 = 3'd7;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_t;

  function automatic logic [3:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      WRAP4,  INCR4:  burst_len = 4'd3;
      WRAP8,  INCR8:  burst_len = 4'd7;
      WRAP16, INCR16: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Burst lock tracker for the current address-phase owner.
//   clk, rst        : clock, synchronous active-high reset
//   htrans, hburst  : address-phase signals of the current owner
//   hready, hresp   : subordinate handshake / error response
//   req             : request line of the current owner
//   lock            : the owner keeps the bus across the coming edge
// lock reflects the state after the current edge so that the edge accepting
// the final beat of a fixed burst can already hand the bus over.
module ahb_burst_tracker
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  input  logic       hresp,
  input  logic       req,
  output logic       lock
);

  logic       lock_q, lock_d;
  logic       incr_q, incr_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    lock_d     = lock_q;
    incr_d     = incr_q;
    beat_cnt_d = beat_cnt_q;
    if (hresp && !hready) begin
      // First error cycle abandons the burst.
      lock_d     = 1'b0;
      incr_d     = 1'b0;
      beat_cnt_d = 4'd0;
    end else if (hready) begin
      if (!req) begin
        lock_d     = 1'b0;
        incr_d     = 1'b0;
        beat_cnt_d = 4'd0;
      end else begin
        case (htrans)
          NSEQ: begin
            lock_d     = (hburst != SINGLE);
            incr_d     = (hburst == INCR);
            beat_cnt_d = burst_len(hburst);
          end
          SEQ: begin
            // Undefined-length INCR never counts down.
            if (lock_q && !incr_q) begin
              if (beat_cnt_q <= 4'd1) begin
                lock_d     = 1'b0;
                beat_cnt_d = 4'd0;
              end else begin
                beat_cnt_d = beat_cnt_q - 4'd1;
              end
            end
          end
          IDLE: begin
            lock_d     = 1'b0;
            incr_d     = 1'b0;
            beat_cnt_d = 4'd0;
          end
          default: ; // BUSY keeps the burst as it is
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      incr_q     <= 1'b0;
      beat_cnt_q <= 4'd0;
    end else begin
      lock_q     <= lock_d;
      incr_q     <= incr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign lock = lock_d;

endmodule

// File: rtl/ahb_manager_arbiter.sv
// Two-manager AHB-Lite arbiter and bus multiplexer onto one subordinate port.
//   m0_*/m1_*  : per-manager request and address/data-phase signals
//   m0_grant, m1_grant : manager owns the address phase this cycle
//   hsel..hwdata       : muxed subordinate-side bus
//   hrdata, hresp, hready -> m_hrdata, m_hresp, m_hready : broadcast response
// Round-robin on ties, fixed-length bursts are never broken.
module ahb_manager_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m1_req,
  output logic                    m0_grant,
  output logic                    m1_grant,
  input  logic                    m0_hsel,
  input  logic [ADDR_WIDTH-1:0]   m0_haddr,
  input  logic [2:0]              m0_hsize,
  input  logic [1:0]              m0_htrans,
  input  logic [2:0]              m0_hburst,
  input  logic                    m0_hwrite,
  input  logic [DATA_WIDTH*8-1:0] m0_hwdata,
  input  logic                    m1_hsel,
  input  logic [ADDR_WIDTH-1:0]   m1_haddr,
  input  logic [2:0]              m1_hsize,
  input  logic [1:0]              m1_htrans,
  input  logic [2:0]              m1_hburst,
  input  logic                    m1_hwrite,
  input  logic [DATA_WIDTH*8-1:0] m1_hwdata,
  output logic                    hsel,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [2:0]              hsize,
  output logic [1:0]              htrans,
  output logic [2:0]              hburst,
  output logic                    hwrite,
  output logic [DATA_WIDTH*8-1:0] hwdata,
  input  logic [DATA_WIDTH*8-1:0] hrdata,
  input  logic                    hresp,
  input  logic                    hready,
  output logic [DATA_WIDTH*8-1:0] m_hrdata,
  output logic                    m_hresp,
  output logic                    m_hready
);

  owner_t     addr_owner, data_owner, last_owner, next_owner;
  logic       own_req, lock;
  logic [1:0] own_htrans;
  logic [2:0] own_hburst;

  assign m0_grant = (addr_owner == M0);
  assign m1_grant = (addr_owner == M1);

  // Address-phase mux; own_* are the owner's raw signals for the tracker.
  always_comb begin
    hsel       = 1'b0;
    haddr      = '0;
    hsize      = 3'd0;
    own_htrans = IDLE;
    hburst     = SINGLE;
    hwrite     = 1'b0;
    own_req    = 1'b0;
    case (addr_owner)
      M0: begin
        hsel       = m0_hsel;
        haddr      = m0_haddr;
        hsize      = m0_hsize;
        own_htrans = m0_htrans;
        hburst     = m0_hburst;
        hwrite     = m0_hwrite;
        own_req    = m0_req;
      end
      M1: begin
        hsel       = m1_hsel;
        haddr      = m1_haddr;
        hsize      = m1_hsize;
        own_htrans = m1_htrans;
        hburst     = m1_hburst;
        hwrite     = m1_hwrite;
        own_req    = m1_req;
      end
      default: ;
    endcase
    own_hburst = hburst;
    // Cancel the pending transfer during the first cycle of an error response.
    htrans = (hresp && !hready) ? IDLE : own_htrans;
  end

  always_comb begin
    case (data_owner)
      M0:      hwdata = m0_hwdata;
      M1:      hwdata = m1_hwdata;
      default: hwdata = '0;
    endcase
  end

  assign m_hrdata = hrdata;
  assign m_hresp  = hresp;
  assign m_hready = hready;

  ahb_burst_tracker u_burst_tracker (
    .clk    (clk),
    .rst    (rst),
    .htrans (own_htrans),
    .hburst (own_hburst),
    .hready (hready),
    .hresp  (hresp),
    .req    (own_req),
    .lock   (lock)
  );

  always_comb begin
    next_owner = NONE;
    if (lock && own_req) begin
      next_owner = addr_owner;
    end else if (m0_req && m1_req) begin
      next_owner = (last_owner == M0) ? M1 : M0;
    end else if (m0_req) begin
      next_owner = M0;
    end else if (m1_req) begin
      next_owner = M1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_owner <= NONE;
      data_owner <= NONE;
      last_owner <= M1;
    end else if (hready) begin
      data_owner <= (own_htrans == NSEQ || own_htrans == SEQ) ? addr_owner : NONE;
      addr_owner <= next_owner;
      if (next_owner != NONE && next_owner != addr_owner) begin
        last_owner <= next_owner;
      end
    end
  end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Self-checking bench for ahb_manager_arbiter: directed scenarios followed by
// randomized well-formed manager traffic, all compared against a behavioural
// ownership/burst model kept in this file.
module tb_ahb_manager_arbiter;

  localparam int DW = 2;
  localparam int AW = 4;
  localparam int DB = DW * 8;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_WRAP4  = 3'd2;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_WRAP8  = 3'd4;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_WRAP16 = 3'd6;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req   [2];
  logic          sel   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [2:0]    size  [2];
  logic [2:0]    burst [2];
  logic [1:0]    trans [2];
  logic [DB-1:0] wdata [2];
  logic [DB-1:0] rdata;
  logic          resp, ready;

  logic          g0, g1, o_hsel, o_hwrite, o_resp, o_ready;
  logic [AW-1:0] o_haddr;
  logic [2:0]    o_hsize, o_hburst;
  logic [1:0]    o_htrans;
  logic [DB-1:0] o_hwdata, o_rdata;

  ahb_manager_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m1_req(req[1]), .m0_grant(g0), .m1_grant(g1),
    .m0_hsel(sel[0]), .m0_haddr(addr[0]), .m0_hsize(size[0]), .m0_htrans(trans[0]),
    .m0_hburst(burst[0]), .m0_hwrite(wr[0]), .m0_hwdata(wdata[0]),
    .m1_hsel(sel[1]), .m1_haddr(addr[1]), .m1_hsize(size[1]), .m1_htrans(trans[1]),
    .m1_hburst(burst[1]), .m1_hwrite(wr[1]), .m1_hwdata(wdata[1]),
    .hsel(o_hsel), .haddr(o_haddr), .hsize(o_hsize), .htrans(o_htrans),
    .hburst(o_hburst), .hwrite(o_hwrite), .hwdata(o_hwdata),
    .hrdata(rdata), .hresp(resp), .hready(ready),
    .m_hrdata(o_rdata), .m_hresp(o_resp), .m_hready(o_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: owners as 0 = none, 1 = M0, 2 = M1; m_rem = beats of the owner's
  // burst still to come (-1 for an open-ended INCR burst).
  int m_owner, m_downer, m_last, m_rem;
  int pending [2];
  bit last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input logic [2:0] hb);
    case (hb)
      B_WRAP4, B_INCR4:   return 4;
      B_WRAP8, B_INCR8:   return 8;
      B_WRAP16, B_INCR16: return 16;
      default:            return 1;
    endcase
  endfunction

  task automatic model_edge();
    int  ot, nxt;
    bit  oreq;
    if (rst) begin
      m_owner = 0; m_downer = 0; m_last = 2; m_rem = 0;
      return;
    end
    if (resp && !ready) begin
      m_rem = 0;
      return;
    end
    if (!ready) return;
    oreq = (m_owner != 0) && req[m_owner-1];
    ot   = (m_owner != 0) ? int'(trans[m_owner-1]) : int'(T_IDLE);
    if (!oreq) m_rem = 0;
    else if (ot == int'(T_NSEQ)) begin
      if (burst[m_owner-1] == B_SINGLE) m_rem = 0;
      else if (burst[m_owner-1] == B_INCR) m_rem = -1;
      else m_rem = beats(burst[m_owner-1]) - 1;
    end else if (ot == int'(T_SEQ)) begin
      if (m_rem > 0) m_rem--;
    end else if (ot == int'(T_IDLE)) m_rem = 0;
    m_downer = (ot == int'(T_NSEQ) || ot == int'(T_SEQ)) ? m_owner : 0;
    if (oreq && m_rem != 0) nxt = m_owner;
    else if (req[0] && req[1]) nxt = (m_last == 1) ? 2 : 1;
    else if (req[0]) nxt = 1;
    else if (req[1]) nxt = 2;
    else nxt = 0;
    if (nxt != 0 && nxt != m_owner) m_last = nxt;
    m_owner = nxt;
  endtask

  task automatic gen_edge();
    if (rst) begin
      pending[0] = 0; pending[1] = 0;
    end else if (ready && !resp) begin
      for (int i = 0; i < 2; i++)
        if (m_owner == i + 1 && pending[i] > 0 && (trans[i] == T_NSEQ || trans[i] == T_SEQ))
          pending[i]--;
    end
  endtask

  task automatic check_all();
    logic [13:0]   exp_bus;
    logic [DB-1:0] exp_wd;
    logic [1:0]    exp_tr;
    int            i;
    exp_bus = '0;
    if (m_owner != 0) begin
      i = m_owner - 1;
      exp_tr  = (resp && !ready) ? T_IDLE : trans[i];
      exp_bus = {sel[i], addr[i], size[i], exp_tr, burst[i], wr[i]};
    end
    exp_wd = (m_downer == 0) ? '0 : wdata[m_downer-1];
    chk("grant", {30'd0, g1, g0}, {30'd0, m_owner == 2, m_owner == 1});
    chk("addr_bus", {18'd0, o_hsel, o_haddr, o_hsize, o_htrans, o_hburst, o_hwrite},
        {18'd0, exp_bus});
    chk("hwdata", {16'd0, o_hwdata}, {16'd0, exp_wd});
    chk("resp", {14'd0, o_rdata, o_resp, o_ready}, {14'd0, rdata, resp, ready});
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    gen_edge();
    model_edge();
    last_ready = ready;
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; sel[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; size[i] = 3'd0;
      burst[i] = B_SINGLE; trans[i] = T_IDLE; wdata[i] = '0;
    end
    ready = 1'b1; resp = 1'b0; rdata = DB'($urandom);
  endtask

  task automatic drive_m(input int i, input bit r, input logic [1:0] t, input logic [2:0] b,
                         input logic [AW-1:0] a, input logic [DB-1:0] d);
    req[i] = r; sel[i] = 1'b1; addr[i] = a; size[i] = 3'd1;
    trans[i] = t; burst[i] = b; wr[i] = 1'b1; wdata[i] = d;
  endtask

  task automatic gen_drive();
    logic [2:0] b;
    for (int i = 0; i < 2; i++) begin
      if (m_owner == i + 1) begin
        if (pending[i] > 0) drive_m(i, 1'b1, T_SEQ, burst[i], AW'($urandom), DB'($urandom));
        else begin
          case ($urandom % 4)
            0: drive_m(i, 1'($urandom), T_IDLE, B_SINGLE, AW'($urandom), DB'($urandom));
            1: drive_m(i, 1'($urandom), T_NSEQ, B_SINGLE, AW'($urandom), DB'($urandom));
            default: begin
              b = 3'($urandom_range(7, 2));
              drive_m(i, 1'b1, T_NSEQ, b, AW'($urandom), DB'($urandom));
              pending[i] = beats(b);
            end
          endcase
        end
      end else begin
        drive_m(i, ($urandom % 4) != 0, 2'($urandom), 3'($urandom), AW'($urandom),
                DB'($urandom));
      end
      size[i] = 3'($urandom);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    pending[0] = 0; pending[1] = 0;
    m_owner = 0; m_downer = 0; m_last = 2; m_rem = 0;
    last_ready = 1'b1;

    // Reset held two cycles with both managers requesting.
    rst = 1'b1;
    idle_all();
    req[0] = 1'b1; req[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      settle();
      chk("rst_grant", {30'd0, g1, g0}, 32'd0);
      chk("rst_htrans", {30'd0, o_htrans}, {30'd0, T_IDLE});
    end
    rst = 1'b0;
    tick();
    settle();
    chk("tie_m0", {30'd0, g1, g0}, 32'd1);

    // Single M0 write: address now, data one cycle later.
    req[1] = 1'b0;
    drive_m(0, 1'b1, T_NSEQ, B_SINGLE, 4'h4, 16'h0);
    settle();
    chk("t2_haddr", {28'd0, o_haddr}, 32'h4);
    tick();
    drive_m(0, 1'b0, T_IDLE, B_SINGLE, 4'h0, 16'h1234);
    settle();
    chk("t2_hwdata", {16'd0, o_hwdata}, 32'h1234);
    tick();

    // Both request single transfers: strict alternation starting with M1.
    exp_g = 2'b10;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) drive_m(i, 1'b1, T_NSEQ, B_SINGLE, AW'($urandom), DB'($urandom));
      settle();
      tick();
      chk("t3_alt", {30'd0, g1, g0}, {30'd0, exp_g});
      exp_g = ~exp_g;
    end

    // M1 INCR4 while M0 waits: bus moves on the edge accepting beat 4.
    drive_m(0, 1'b1, T_NSEQ, B_SINGLE, 4'h1, 16'h1111);
    for (int k = 0; k < 4; k++) begin
      drive_m(1, 1'b1, (k == 0) ? T_NSEQ : T_SEQ, B_INCR4, AW'(k * 2), DB'($urandom));
      settle();
      tick();
      chk("t4_hold", {30'd0, g1, g0}, (k < 3) ? 32'd2 : 32'd1);
    end

    // M0 WRAP4 with a 3-cycle stall on beat 2.
    drive_m(1, 1'b1, T_NSEQ, B_SINGLE, 4'h3, 16'h3333);
    drive_m(0, 1'b1, T_NSEQ, B_WRAP4, 4'h8, 16'h0);
    settle();
    tick();
    drive_m(0, 1'b1, T_SEQ, B_WRAP4, 4'hA, 16'hBEEF);
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("t5_grant", {30'd0, g1, g0}, 32'd1);
      chk("t5_haddr", {28'd0, o_haddr}, 32'hA);
      chk("t5_hwdata", {16'd0, o_hwdata}, 32'hBEEF);
      tick();
    end
    ready = 1'b1;
    settle();
    tick();
    chk("t5_after_stall", {30'd0, g1, g0}, 32'd1);
    drive_m(0, 1'b1, T_SEQ, B_WRAP4, 4'hC, 16'hC0C0);
    settle();
    tick();
    chk("t5_beat3", {30'd0, g1, g0}, 32'd1);
    drive_m(0, 1'b1, T_SEQ, B_WRAP4, 4'hE, 16'hE0E0);
    settle();
    tick();
    chk("t5_handover", {30'd0, g1, g0}, 32'd2);

    // Error response on beat 3 of an M1 INCR8.
    drive_m(0, 1'b1, T_NSEQ, B_SINGLE, 4'h5, 16'h5555);
    drive_m(1, 1'b1, T_NSEQ, B_INCR8, 4'h0, 16'h0);
    settle();
    tick();
    drive_m(1, 1'b1, T_SEQ, B_INCR8, 4'h2, 16'h2222);
    settle();
    tick();
    chk("t6_locked", {30'd0, g1, g0}, 32'd2);
    drive_m(1, 1'b1, T_SEQ, B_INCR8, 4'h4, 16'h4444);
    resp = 1'b1; ready = 1'b0;
    settle();
    chk("t6_idle", {30'd0, o_htrans}, {30'd0, T_IDLE});
    tick();
    ready = 1'b1;
    settle();
    tick();
    chk("t6_m0", {30'd0, g1, g0}, 32'd1);
    resp = 1'b0;

    // Reset in the middle of an M0 INCR16.
    req[1] = 1'b0;
    drive_m(0, 1'b1, T_NSEQ, B_INCR16, 4'h0, 16'h0);
    settle();
    tick();
    drive_m(0, 1'b1, T_SEQ, B_INCR16, 4'h2, 16'h7777);
    settle();
    tick();
    rst = 1'b1;
    settle();
    tick();
    chk("t7_rst_idle", {28'd0, g1, g0, o_htrans}, 32'd0);
    rst = 1'b0;

    // Randomized traffic from well-behaved managers with random stalls.
    idle_all();
    settle();
    tick();
    for (int n = 0; n < 3000; n++) begin
      if (last_ready) gen_drive();
      ready = ($urandom % 5) != 0;
      resp  = 1'b0;
      rdata = DB'($urandom);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
